// File: rtl/hdmi_axi_line_addr_gen_if.sv
// Read-request bus between the scan-out address generator and the AXI read master.
//
// Handshake: the generator raises kick with read_addr/read_num stable and keeps
// all three unchanged until it samples busy=1 on a rising clk_vga edge; that
// edge is the transfer. kick then drops for at least one cycle. While busy=1
// the generator does not prepare a new request.
interface hdmi_axi_line_addr_gen_if #(
    parameter int ADDR_W = 32
);
    logic              kick;
    logic [ADDR_W-1:0] read_addr;
    logic [31:0]       read_num;
    logic              busy;

    modport master (output kick, output read_addr, output read_num, input busy);
    modport slave  (input kick, input read_addr, input read_num, output busy);
endinterface

// File: rtl/hdmi_axi_line_addr_gen.sv
// HDMI scan-out read-address generator: walks a frame line by line and issues
// one burst request per BURST_PIXELS chunk, with a shorter final burst when
// the line length is not a burst multiple. Frame base and line stride are
// captured at frame start so a double-buffer flip takes effect cleanly.
module hdmi_axi_line_addr_gen #(
    parameter int X_SIZE       = 256,
    parameter int Y_SIZE       = 256,
    parameter int BPP_BYTES    = 4,
    parameter int BURST_PIXELS = 64,
    parameter int ADDR_W       = 32
) (
    input  logic                     clk_vga,
    input  logic                     rst,
    input  logic                     prefetch_line,
    input  logic [1:0]               pixelena_edge,
    input  logic [ADDR_W-1:0]        frame_base,
    input  logic [ADDR_W-1:0]        line_stride,
    hdmi_axi_line_addr_gen_if.master rd,
    output logic                     line_done,
    output logic                     frame_done,
    output logic                     active,
    output logic [1:0]               dbg_state
);

    // Pixel-to-byte scaling is a shift; only 1, 2 and 4 bytes/pixel are legal.
    localparam int          BPP_SHIFT = (BPP_BYTES == 4) ? 2 : (BPP_BYTES == 2) ? 1 : 0;
    localparam logic [11:0] X_LAST    = 12'(X_SIZE);
    localparam logic [11:0] Y_LAST    = 12'(Y_SIZE);
    localparam logic [11:0] BURST_MAX = 12'(BURST_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FREE  = 2'd1,
        S_ISSUE = 2'd2,
        S_LINE  = 2'd3
    } state_t;

    state_t            state;
    logic [11:0]       x_cnt;
    logic [11:0]       y_cnt;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] addr_q;
    logic [11:0]       num_q;

    logic [11:0]       remaining;
    logic [11:0]       burst_num;
    logic [11:0]       x_next;
    logic [11:0]       y_next;
    logic [ADDR_W-1:0] x_off;

    // Next-request sizing and counter increments; x_cnt + num never exceeds X_SIZE.
    always_comb begin
        remaining = X_LAST - x_cnt;
        burst_num = (remaining > BURST_MAX) ? BURST_MAX : remaining;
        x_next    = x_cnt + num_q;
        y_next    = y_cnt + 12'd1;
        x_off     = ADDR_W'(x_cnt) << BPP_SHIFT;
    end

    // Frame walk: request preparation, handshake, end-of-line and end-of-frame bookkeeping.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state      <= S_IDLE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            line_addr  <= '0;
            stride_q   <= '0;
            addr_q     <= '0;
            num_q      <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (prefetch_line) begin
                        line_addr <= frame_base;
                        stride_q  <= line_stride;
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                        state     <= S_FREE;
                    end
                end
                S_FREE: begin
                    if (!rd.busy) begin
                        addr_q <= line_addr + x_off;
                        num_q  <= burst_num;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (rd.busy) begin
                        if (x_next == X_LAST) begin
                            x_cnt     <= '0;
                            y_cnt     <= y_next;
                            line_addr <= line_addr + stride_q;
                            line_done <= 1'b1;
                            if (y_next == Y_LAST) begin
                                frame_done <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                state <= S_LINE;
                            end
                        end else begin
                            x_cnt <= x_next;
                            state <= S_FREE;
                        end
                    end
                end
                S_LINE: begin
                    if (pixelena_edge == 2'b01) begin
                        state <= S_FREE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decodes of registered state, so kick drops the cycle after reset.
    assign rd.kick      = (state == S_ISSUE);
    assign rd.read_addr = addr_q;
    assign rd.read_num  = {20'd0, num_q};
    assign active       = (state != S_IDLE);
    assign dbg_state    = state;

endmodule
